// File: rtl/shift_reg_mem_if.sv
`default_nettype none
// ============================================================================
// Module : shift_reg_mem_if
// Brief  : Data bus of the shift_reg_mem delay line (ce only with SHIFT_REG_CE_EN).
// Rev    : 1.0  initial release
// ============================================================================
interface shift_reg_mem_if #(
   parameter int WIDTH = 25
);
`ifdef SHIFT_REG_CE_EN
   logic             ce;
`endif
   logic [WIDTH-1:0] di;
   logic [WIDTH-1:0] data_o;

   modport master (
`ifdef SHIFT_REG_CE_EN
      output ce,
`endif
      output di,
      input  data_o
   );

   modport slave (
`ifdef SHIFT_REG_CE_EN
      input  ce,
`endif
      input  di,
      output data_o
   );
endinterface
`default_nettype wire

// File: rtl/shift_reg_mem.sv
`default_nettype none
// ============================================================================
// Module : shift_reg_mem
// Brief  : LEN-cycle delay line built as a RAM circular buffer plus output
//          register; SHIFT_REG_CE_EN adds a clock enable (bus.ce).
// Rev    : 1.0  initial release
// ============================================================================
module shift_reg_mem #(
   parameter int WIDTH = 25,
   parameter int LEN   = 512
) (
   input  logic            clk,
   input  logic            rst,
   shift_reg_mem_if.slave  bus
);

   logic w_shift;

`ifdef SHIFT_REG_CE_EN
   assign w_shift = bus.ce;
`else
   assign w_shift = 1'b1;
`endif

   generate
      if (LEN == 1) begin : g_len_one
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               bus.data_o <= '0;
            end else if (w_shift) begin
               bus.data_o <= bus.di;
            end
         end
      end else begin : g_ram
         localparam int c_DEPTH  = LEN - 1;
         localparam int c_PTR_W  = (c_DEPTH > 1) ? $clog2(c_DEPTH) : 1;
         localparam int c_FILL_W = $clog2(LEN);
         localparam logic [c_PTR_W-1:0]  c_PTR_LAST = c_PTR_W'(LEN - 2);
         localparam logic [c_FILL_W-1:0] c_FILL_MAX = c_FILL_W'(LEN - 1);

         logic [WIDTH-1:0]    r_mem [c_DEPTH];
         logic [c_PTR_W-1:0]  r_ptr;
         logic [c_FILL_W-1:0] r_fill;
         logic                w_full;

         assign w_full = (r_fill == c_FILL_MAX);

         // RAM is never reset so it maps onto block RAM; the fill counter hides stale words.
         always_ff @(posedge clk) begin
            if (w_shift) begin
               r_mem[r_ptr] <= bus.di;
            end
         end

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               r_ptr      <= '0;
               r_fill     <= '0;
               bus.data_o <= '0;
            end else if (w_shift) begin
               // Read of the old word at r_ptr happens in the same edge as its overwrite.
               bus.data_o <= w_full ? r_mem[r_ptr] : '0;
               r_ptr      <= (r_ptr == c_PTR_LAST) ? '0 : r_ptr + c_PTR_W'(1);
               if (!w_full) begin
                  r_fill <= r_fill + c_FILL_W'(1);
               end
            end
         end
      end
   endgenerate

endmodule
`default_nettype wire

// File: tb/tb_shift_reg_mem.sv
`default_nettype none
// ============================================================================
// Module : tb_shift_reg_mem
// Brief  : Self-checking bench: five delay-line configurations against a history-queue model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_shift_reg_mem;

   logic clk;
   logic rst;

   shift_reg_mem_if #(.WIDTH(8))  if4   ();
   shift_reg_mem_if #(.WIDTH(8))  if1   ();
   shift_reg_mem_if #(.WIDTH(25)) if512 ();
   shift_reg_mem_if #(.WIDTH(8))  if8   ();
   shift_reg_mem_if #(.WIDTH(1))  if3   ();

   shift_reg_mem #(.WIDTH(8),  .LEN(4))   u4   (.clk(clk), .rst(rst), .bus(if4.slave));
   shift_reg_mem #(.WIDTH(8),  .LEN(1))   u1   (.clk(clk), .rst(rst), .bus(if1.slave));
   shift_reg_mem #(.WIDTH(25), .LEN(512)) u512 (.clk(clk), .rst(rst), .bus(if512.slave));
   shift_reg_mem #(.WIDTH(8),  .LEN(8))   u8   (.clk(clk), .rst(rst), .bus(if8.slave));
   shift_reg_mem #(.WIDTH(1),  .LEN(3))   u3   (.clk(clk), .rst(rst), .bus(if3.slave));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_chk  = 0;
   int n_pass = 0;

   // Every word accepted since the last reset; output after n shifts is word n-LEN or zero.
   logic [31:0] hist [$];

   function automatic logic [31:0] model_out(input int len, input int width);
      logic [31:0] mask;
      int          n;
      mask = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
      n    = hist.size();
      if (n >= len) return hist[n-len] & mask;
      return 32'd0;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   task automatic check_model();
      chk("model_len4",   32'(if4.data_o),   model_out(4, 8));
      chk("model_len1",   32'(if1.data_o),   model_out(1, 8));
      chk("model_len512", 32'(if512.data_o), model_out(512, 25));
      chk("model_len8",   32'(if8.data_o),   model_out(8, 8));
      chk("model_len3",   32'(if3.data_o),   model_out(3, 1));
   endtask

   // Called at a negedge; returns at the next negedge after one rising edge.
   task automatic step(input logic [31:0] d, input logic e);
      if4.di   = d[7:0];
      if1.di   = d[7:0];
      if512.di = d[24:0];
      if8.di   = d[7:0];
      if3.di   = d[0:0];
`ifdef SHIFT_REG_CE_EN
      if4.ce = e; if1.ce = e; if512.ce = e; if8.ce = e; if3.ce = e;
`endif
      @(posedge clk);
      if (e) hist.push_back(d);
      #1;
      check_model();
      @(negedge clk);
   endtask

   // Asserts rst between edges and checks the outputs clear with no clock edge.
   task automatic do_reset();
      rst = 1'b1;
      #1;
      chk("rst_async_len4",   32'(if4.data_o),   32'd0);
      chk("rst_async_len1",   32'(if1.data_o),   32'd0);
      chk("rst_async_len512", 32'(if512.data_o), 32'd0);
      chk("rst_async_len8",   32'(if8.data_o),   32'd0);
      chk("rst_async_len3",   32'(if3.data_o),   32'd0);
      hist.delete();
      @(negedge clk);
      rst = 1'b0;
   endtask

   typedef struct {
      logic [7:0] di;
      logic [7:0] exp4;
      logic [7:0] exp1;
   } vec_t;

   vec_t        vecs [8];
   logic [31:0] d;
   logic        e;
   logic        pulse_exp [6];

   initial begin
      vecs[0] = '{8'hA5, 8'h00, 8'hA5};
      vecs[1] = '{8'h02, 8'h00, 8'h02};
      vecs[2] = '{8'h03, 8'h00, 8'h03};
      vecs[3] = '{8'h04, 8'hA5, 8'h04};
      vecs[4] = '{8'h05, 8'h02, 8'h05};
      vecs[5] = '{8'h06, 8'h03, 8'h06};
      vecs[6] = '{8'h07, 8'h04, 8'h07};
      vecs[7] = '{8'h08, 8'h05, 8'h08};
      pulse_exp = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

      rst = 1'b0;
      if4.di = '0; if1.di = '0; if512.di = '0; if8.di = '0; if3.di = '0;
`ifdef SHIFT_REG_CE_EN
      if4.ce = 1'b1; if1.ce = 1'b1; if512.ce = 1'b1; if8.ce = 1'b1; if3.ce = 1'b1;
`endif
      @(negedge clk);
      do_reset();

      // LEN=4 latency and LEN=1 pass-through from the table
      for (int i = 0; i < 8; i++) begin
         step(32'(vecs[i].di), 1'b1);
         chk("table_len4", 32'(if4.data_o), 32'(vecs[i].exp4));
         chk("table_len1", 32'(if1.data_o), 32'(vecs[i].exp1));
      end

      // Single-cycle pulse through the 1-bit, 3-deep line
      do_reset();
      for (int i = 0; i < 6; i++) begin
         step((i == 0) ? 32'd1 : 32'd0, 1'b1);
         chk("pulse_len3", 32'(if3.data_o), 32'(pulse_exp[i]));
      end

      // Fill with 0xFF, reset mid-stream, then zeros must never reveal a stale word
      for (int i = 0; i < 20; i++) step(32'hFFFF_FFFF, 1'b1);
      do_reset();
      for (int i = 0; i < 20; i++) begin
         step(32'd0, 1'b1);
         chk("no_stale_len8",   32'(if8.data_o), 32'd0);
         chk("no_stale_len4",   32'(if4.data_o), 32'd0);
      end

`ifdef SHIFT_REG_CE_EN
      // Only enabled edges count towards the delay
      do_reset();
      for (int k = 1; k <= 8; k++) begin
         step(32'(k), (k % 2) == 1);
         if (k == 6) chk("ce_len4_before", 32'(if4.data_o), 32'd0);
         if (k == 7) chk("ce_len4_fourth", 32'(if4.data_o), 32'd1);
         if (k == 8) chk("ce_len4_hold",   32'(if4.data_o), 32'd1);
      end
`endif

      // Random stream across several wraps of the 511-entry buffer
      do_reset();
      for (int i = 0; i < 2000; i++) begin
         d = $urandom;
         if (i == 700)  d = 32'hFFFF_FFFF;
         if (i == 1300) d = 32'h0100_0000;
         if (i == 1301) d = 32'h00FF_FFFF;
`ifdef SHIFT_REG_CE_EN
         e = ($urandom_range(0, 3) != 0);
`else
         e = 1'b1;
`endif
         step(d, e);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
